gpio_bank: RTL and testbench

- Parametrised GPIO peripheral that replaces the CPU's direct GPIO_in/GPIO_out wiring.
- Synchronises raw external inputs, detects rising edges into sticky event bits, and raises a maskable interrupt.
- Holds an output register that the CPU can write, set, clear or toggle through a simple register port.
- Sits between the cpu core's IO write/read path and the board pins.

---
 rtl/gpio_bank.sv | 183 ++++++++++++++++++
 tb/tb_gpio_bank.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank.sv
// gpio_bank: GPIO peripheral with synchronised inputs, rising-edge event
// capture, a maskable interrupt and a CPU-writable output register.
//
// Optional feature macro: GPIO_DEBOUNCE_EN. When it is defined, each input
// bit gets a saturating stability counter. A new level reaches the filtered
// input only after it has differed from the accepted level for DEB_CYCLES
// consecutive cycles. When it is undefined, no counters exist and the
// filtered input is the synchroniser output.
//
// Ports:
//   clk, rst_n  - system clock; synchronous active-low reset
//   gpio_in     - raw asynchronous pin inputs (WIDTH)
//   gpio_out    - output register, driven straight from a flop (WIDTH)
//   wr_en       - write strobe
//   wr_sel      - 0 OUT load, 1 OUT set, 2 OUT clear, 3 OUT toggle,
//                 4 EVENT write-1-to-clear, 5 MASK load, 6..7 ignored
//   wr_data     - write data (WIDTH)
//   rd_sel      - 0 IN (filtered), 1 OUT, 2 EVENT, 3 MASK
//   rd_data     - registered read data (WIDTH)
//   irq         - |(EVENT & MASK)

// Per-bit input path: synchroniser, optional debounce, rising-edge detect.
module gpio_lane #(
  parameter int SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
  , parameter int DEB_CYCLES = 4
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic filt,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   in_sync;
  logic                   filt_prev_q, filt_prev_d;

  assign in_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], din};
    filt_prev_d = filt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q      <= '0;
      filt_prev_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      filt_prev_q <= filt_prev_d;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  // Counter tracks how long in_sync has disagreed with the accepted level.
  // The >= compare keeps the counter saturating even if it were ever
  // corrupted past the terminal value.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (in_sync == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      filt_d = in_sync;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;
`else
  assign filt = in_sync;
`endif

  assign rise = filt & ~filt_prev_q;
endmodule

module gpio_bank #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  input  logic             wr_en,
  input  logic [2:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             irq
);
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("gpio_bank: SYNC_STAGES must be 2..4");
  end
  if (DEB_CYCLES < 2 || DEB_CYCLES > 255) begin : g_bad_deb
    $error("gpio_bank: DEB_CYCLES must be 2..255");
  end

  logic [WIDTH-1:0] filt, rise;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] event_q, event_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WIDTH-1:0] w1c;

  gpio_lane #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef GPIO_DEBOUNCE_EN
    , .DEB_CYCLES(DEB_CYCLES)
`endif
  ) u_lane [WIDTH-1:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (gpio_in),
    .filt (filt),
    .rise (rise)
  );

  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    w1c    = '0;
    if (wr_en) begin
      case (wr_sel)
        3'd0:    out_d  = wr_data;
        3'd1:    out_d  = out_q | wr_data;
        3'd2:    out_d  = out_q & ~wr_data;
        3'd3:    out_d  = out_q ^ wr_data;
        3'd4:    w1c    = wr_data;
        3'd5:    mask_d = wr_data;
        default: ;
      endcase
    end
    // OR-ing rise after the clear lets a fresh edge win over a same-cycle clear.
    event_d = (event_q & ~w1c) | rise;
    // Read mux uses current flop values, so a same-edge write is not visible.
    case (rd_sel)
      2'd0:    rd_data_d = filt;
      2'd1:    rd_data_d = out_q;
      2'd2:    rd_data_d = event_q;
      default: rd_data_d = mask_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q     <= '0;
      event_q   <= '0;
      mask_q    <= '0;
      rd_data_q <= '0;
    end else begin
      out_q     <= out_d;
      event_q   <= event_d;
      mask_q    <= mask_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign gpio_out = out_q;
  assign rd_data  = rd_data_q;
  assign irq      = |(event_q & mask_q);
endmodule

// File: tb/tb_gpio_bank.sv
// Testbench for gpio_bank: directed sequence plus randomized traffic. A
// history-based reference model predicts the DUT state after every clock
// edge; predictions go into a queue that a separate monitor drains and
// compares on the falling edge. A few directed points also compare
// against literal constants.
module tb_gpio_bank;
  localparam int W    = 32;
  localparam int S    = 2;
  localparam int DEB  = 4;
  localparam int MAXC = 8192;
`ifdef GPIO_DEBOUNCE_EN
  localparam int EXTRA = DEB;
`else
  localparam int EXTRA = 0;
`endif

  logic         clk;
  logic         rst_n;
  logic [W-1:0] gpio_in, gpio_out, wr_data, rd_data;
  logic         wr_en, irq;
  logic [2:0]   wr_sel;
  logic [1:0]   rd_sel;

  gpio_bank #(.WIDTH(W), .SYNC_STAGES(S), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .rd_sel(rd_sel),
    .rd_data(rd_data), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: per-cycle input/reset history plus architectural state.
  typedef struct packed {
    logic [W-1:0] out;
    logic [W-1:0] rd;
    logic         irq;
  } exp_t;
  exp_t sbq[$];

  logic [W-1:0] in_h   [0:MAXC];
  bit           rst_h  [0:MAXC];
  logic [W-1:0] sync_h [0:MAXC];
  logic [W-1:0] filt_h [0:MAXC];
  logic [W-1:0] m_out, m_ev, m_mask, m_fprev;
  int           cyc_n;

  // Drive one cycle of inputs, predict the state after the next posedge,
  // then advance to just after that posedge.
  task automatic cyc(input bit rst, input bit we, input logic [2:0] ws,
                     input logic [W-1:0] wd, input logic [1:0] rs,
                     input logic [W-1:0] gin);
    int           n;
    logic [W-1:0] s, f, rdv, andw, orw, v, rise;
    exp_t         e;
    n = cyc_n + 1;
    if (n >= MAXC) begin
      $display("FAIL history_overflow: got %0d expected < %0d", n, MAXC);
      $fatal(1);
    end
    rst_n = ~rst; wr_en = we; wr_sel = ws; wr_data = wd; rd_sel = rs; gpio_in = gin;
    in_h[n] = gin; rst_h[n] = rst;
    // Synchronised level: input from S-1 cycles ago, zero if any reset since.
    s = (n - S + 1 >= 1) ? in_h[n-S+1] : '0;
    for (int j = n - S + 1; j <= n; j++) if (j < 1 || rst_h[j]) s = '0;
    sync_h[n] = s;
`ifdef GPIO_DEBOUNCE_EN
    // Accepted level moves to v only when the last DEB synchronised
    // samples all equal v.
    if (rst) f = '0;
    else begin
      andw = '1; orw = '0;
      for (int j = n - DEB; j <= n - 1; j++) begin
        v = (j >= 0) ? sync_h[j] : '0;
        andw &= v; orw |= v;
      end
      f = (filt_h[n-1] & orw) | andw;
    end
`else
    f = s;
`endif
    filt_h[n] = f;
    case (rs)
      2'd0:    rdv = filt_h[n-1];
      2'd1:    rdv = m_out;
      2'd2:    rdv = m_ev;
      default: rdv = m_mask;
    endcase
    rise = filt_h[n-1] & ~m_fprev;
    if (rst) begin
      m_out = '0; m_ev = '0; m_mask = '0; m_fprev = '0; rdv = '0;
    end else begin
      m_ev = (m_ev & ~((we && ws == 3'd4) ? wd : '0)) | rise;
      if (we) begin
        if (ws == 3'd0) m_out = wd;
        if (ws == 3'd1) m_out = m_out | wd;
        if (ws == 3'd2) m_out = m_out & ~wd;
        if (ws == 3'd3) m_out = m_out ^ wd;
        if (ws == 3'd5) m_mask = wd;
      end
      m_fprev = filt_h[n-1];
    end
    e.out = m_out; e.rd = rdv; e.irq = |(m_ev & m_mask);
    sbq.push_back(e);
    cyc_n = n;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every falling edge, the oldest prediction matches the DUT.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_gpio_out", gpio_out, e.out);
        chk("sb_rd_data", rd_data, e.rd);
        chk("sb_irq", {{(W-1){1'b0}}, irq}, {{(W-1){1'b0}}, e.irq});
      end
    end
  end

  initial begin
    logic [W-1:0] g;
    int           lo_len;
    bit           r, we;
    logic [2:0]   ws;
    logic [1:0]   rs;
    cyc_n = 0;
    in_h[0] = '0; rst_h[0] = 1'b1; sync_h[0] = '0; filt_h[0] = '0;
    m_out = '0; m_ev = '0; m_mask = '0; m_fprev = '0;

    // Reset overrides a concurrent write.
    cyc(1, 1, 3'd0, '1, 2'd1, '0);
    cyc(1, 1, 3'd0, '1, 2'd1, '0);
    chk("rst_gpio_out", gpio_out, '0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_irq", {31'b0, irq}, '0);
    cyc(0, 0, 3'd0, '0, 2'd1, '0);
    chk("rd_out_after_rst", rd_data, 32'h0000_0000);

    // OUT operations.
    cyc(0, 1, 3'd0, 32'hDEAD_BEEF, 2'd1, '0); chk("out_load",   gpio_out, 32'hDEAD_BEEF);
    cyc(0, 1, 3'd1, 32'h0000_0010, 2'd1, '0); chk("out_set",    gpio_out, 32'hDEAD_BEFF);
    cyc(0, 1, 3'd2, 32'hFF00_0000, 2'd1, '0); chk("out_clear",  gpio_out, 32'h00AD_BEFF);
    cyc(0, 1, 3'd3, 32'h0000_000F, 2'd1, '0); chk("out_toggle", gpio_out, 32'h00AD_BEF0);
    cyc(0, 1, 3'd6, 32'hFFFF_FFFF, 2'd1, '0); chk("out_sel6",   gpio_out, 32'h00AD_BEF0);
    cyc(0, 1, 3'd7, 32'h1234_5678, 2'd1, '0); chk("out_sel7",   gpio_out, 32'h00AD_BEF0);

    // Rising edges: gpio_in goes to 5 before posedge k.
    cyc(0, 0, 3'd0, '0, 2'd2, 32'h5);          // posedge k
    cyc(0, 0, 3'd0, '0, 2'd2, 32'h5);          // k+1
    repeat (EXTRA) cyc(0, 0, 3'd0, '0, 2'd2, 32'h5);
    cyc(0, 0, 3'd0, '0, 2'd2, 32'h5);          // reads EVENT after k+1(+EXTRA)
    chk("ev_not_early", rd_data, 32'h0);
    cyc(0, 0, 3'd0, '0, 2'd2, 32'h5);          // reads EVENT after k+2(+EXTRA)
    chk("ev_rise", rd_data, 32'h5);
    chk("irq_unmasked", {31'b0, irq}, '0);
    cyc(0, 1, 3'd5, 32'h4, 2'd0, 32'h5);
    chk("irq_after_mask", {31'b0, irq}, 32'h1);
    chk("rd_in", rd_data, 32'h5);

    // Rise on bit2 lands on the same edge as a W1C of bit2.
    lo_len = (EXTRA == 0) ? 1 : EXTRA;
    repeat (lo_len) cyc(0, 0, 3'd0, '0, 2'd2, 32'h1);
    repeat (2 + EXTRA) cyc(0, 0, 3'd0, '0, 2'd2, 32'h5);
    cyc(0, 1, 3'd4, 32'h4, 2'd2, 32'h5);
    cyc(0, 0, 3'd0, '0, 2'd2, 32'h5);
    chk("ev_race_rise_wins", rd_data, 32'h5);
    cyc(0, 1, 3'd4, 32'h4, 2'd2, 32'h5);
    chk("irq_after_w1c", {31'b0, irq}, '0);
    cyc(0, 0, 3'd0, '0, 2'd2, 32'h5);
    chk("ev_after_w1c", rd_data, 32'h1);

    // Falling edges do not set EVENT.
    repeat (4 + EXTRA) cyc(0, 0, 3'd0, '0, 2'd2, 32'h0);
    chk("ev_fall", rd_data, 32'h1);
    chk("irq_fall", {31'b0, irq}, '0);

`ifdef GPIO_DEBOUNCE_EN
    cyc(0, 1, 3'd4, 32'h1, 2'd2, 32'h0);
    repeat (3) cyc(0, 0, 3'd0, '0, 2'd2, 32'h1);
    repeat (8) cyc(0, 0, 3'd0, '0, 2'd2, 32'h0);
    chk("deb_glitch_ev", rd_data, 32'h0);
    cyc(0, 0, 3'd0, '0, 2'd0, 32'h0);
    chk("deb_glitch_in", rd_data, 32'h0);
    repeat (4) cyc(0, 0, 3'd0, '0, 2'd2, 32'h1);
    repeat (6) cyc(0, 0, 3'd0, '0, 2'd2, 32'h0);
    chk("deb_level_ev", rd_data, 32'h1);
`endif

    // Randomized traffic with sparse input flips and occasional resets.
    g = '0;
    repeat (3000) begin
      if ($urandom_range(3) == 0) g = g ^ ($urandom & $urandom);
      r  = ($urandom_range(299) == 0);
      we = ($urandom_range(1) == 1);
      ws = 3'($urandom_range(7));
      rs = 2'($urandom_range(3));
      cyc(r, we, ws, $urandom, rs, g);
    end
    cyc(0, 0, 3'd0, '0, 2'd0, g);

    // Hold idle while the monitor drains; bounded wait.
    rst_n = 1'b1; wr_en = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
